decode_queue_stage: RTL
=======================

# decode_queue_stage

Registered, handshaked successor to the combinational decode stage. It buffers fetched instruction bytes in a parametrised byte queue and finds variable-length instruction boundaries (1/2/3/5 bytes). It decodes one instruction per cycle into an output register with PC, immediate, register indices, 7-bit control and length. It sits between fetch and register-read, and supports flush/redirect and a sticky halt.

## Interface
- `FETCH_W`, default 4: bytes per fetch beat.
- `QDEPTH`, default 16: byte-queue depth. Must be a power of two and at least `FETCH_W+5`.
- `RESET_PC`, default 32'h0000_1000: PC of the first queued byte after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  redirect: discard all queued and output state.
- `flush_pc`  in  32  PC of the first byte fetched after the flush.
- `in_valid`  in  1  fetch beat valid.
- `in_ready`  out  1  queue accepts a beat.
- `in_bytes`  in  8*FETCH_W  fetch beat; byte i at [8i+7:8i], lowest address at byte 0.
- `out_valid`  out  1  decoded instruction valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  32  PC of the instruction.
- `out_imm`  out  32  immediate.
- `out_src1_idx`  out  3  destination/source-1 register.
- `out_src2_idx`  out  3  source-2 register.
- `out_ctrl`  out  7  {src2mux, op, read1, read2, we, jmp, halt}.
- `out_length`  out  4  instruction length in bytes.
- `out_illegal`  out  1  unknown opcode (see Configuration).
- `halted`  out  1  sticky halt state.

## Operation
- Queue: read/write pointers of log2(QDEPTH)+1 bits, wrapping modulo QDEPTH; `count` = wr−rd.
- `in_ready` = !flush && !halted && (QDEPTH−count ≥ FETCH_W). It does not credit a same-cycle pop.
- A push writes all FETCH_W bytes.
- Head decode uses byte0 = opcode, plus bytes 1..4. Immediates are little-endian.
  - B8..BF: len 5, imm=bytes1..4, src1=op[2:0], ctrl=1000100.
  - 05: len 5, imm=bytes1..4, src1=0, ctrl=1110100.
  - 01: len 2, src1=modrm[2:0], src2=modrm[5:3], imm=0, ctrl=0111100.
  - 83: len 3, src1=modrm[2:0], imm=sign-extended byte2, ctrl=1110100.
  - E9: len 5, imm=bytes1..4, ctrl=0000010.
  - F4: len 1, ctrl=0000001.
  - Any other opcode: len 1, ctrl=0, treated as NOP.
- Fields not listed above are 0.
- Fire condition: count ≥ len && (!out_valid || out_ready) && !halted && !flush.
- On fire:
  - Output register loads all fields plus `out_pc` = pc_reg.
  - rd += len; pc_reg += len, mod 2^32.
- Output hold: when out_valid && !out_ready, all out_* are held stable. No bytes are consumed.
- Incomplete instruction (count < len): no fire. The instruction waits for more beats and may straddle beats and the queue wrap point.
- Halt: firing F4 sets `halted` on the same edge. After that: in_ready=0, no further fires. The F4 output itself still completes its handshake normally. `halted` clears only on flush or reset.
- JMP is not acted on locally; decode continues sequentially until flush.
- Flush has priority over every other event in its cycle:
  - rd=wr=0, out_valid=0, halted=0, pc_reg=flush_pc.
  - Any same-cycle in_valid beat is not accepted.
- Simultaneous push and fire is allowed. count' = count + FETCH_W − len.

## Timing
- Reset (asynchronous): out_valid=0, out_* fields=0, halted=0, pointers=0, pc_reg=RESET_PC. in_ready=1 after deassertion.
- Latency: if an instruction's last byte is accepted at edge N, out_valid is 1 after edge N+1. If the instruction is already resident and the output register is free, it appears after the next edge.
- Throughput: at most one instruction per cycle. Sustained when out_ready=1 and enough bytes are queued.
- Flush at edge N: out_valid=0 after N. The first beat is accepted at N+1 at the earliest.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN`
  - Defined: an unknown opcode fires with len 1, ctrl=0000001 and out_illegal=1, and sets `halted` exactly as F4 does.
  - Undefined: an unknown opcode is a 1-byte NOP with out_illegal=0. The `out_illegal` port exists but is tied to 0.

## Test plan
- Reset, then beats {B8,EF,BE,AD} and {DE,05,05,00} with out_ready=1.
  - Required: pc=1000, imm=DEADBEEF, src1=0, ctrl=1000100, len=5.
  - Then, once the following beat {00,00,...} arrives: ADD at pc=1005, imm=5, ctrl=1110100.
- Bytes 01,01,83,00,FF.
  - Required: ADD r,r with src1=1, src2=0, ctrl=0111100, len=2.
  - Then 83 at pc+2 with imm=FFFFFFFF, src1=0, len=3.
- Hold out_ready=0 with a queue full of complete instructions.
  - Required: out_* stable, count frozen, in_ready=0 once free space < FETCH_W.
  - Release: instructions drain one per cycle, in order, with PCs incrementing by length.
- F4 followed by B9 78 56 34 12.
  - Required: HALT emitted, halted=1, in_ready=0, MOV not emitted.
  - Then flush with flush_pc=2000 and a new beat: halted=0, next out_pc=2000.
- 5-byte E9 AA 00 00 00 straddling the queue wrap point, with a flush asserted in the same cycle as an in_valid beat.
  - Required: the E9 decodes correctly with jmp=1 and imm=000000AA before the flush.
  - The flush cycle's beat is not accepted, and out_valid=0 after the flush.
- Opcode 0x90.
  - With the macro: out_illegal=1, ctrl=0000001, halted=1.
  - Without the macro: NOP with len 1, and decode continues.

Source files
------------

// File: rtl/decode_queue_stage.sv
// ==== decode_queue_stage (rev 1.0): byte queue + 1/2/3/5-byte decoder, one instr/cycle ====
// Optional macro DECODE_ILLEGAL_TRAP_EN: unknown opcodes trap and halt instead of acting as NOPs.
`default_nettype none

module decode_queue_stage #(
    parameter int          FETCH_W  = 4,
    parameter int          QDEPTH   = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [31:0]          flush_pc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*FETCH_W-1:0] in_bytes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_imm,
    output logic [2:0]           out_src1_idx,
    output logic [2:0]           out_src2_idx,
    output logic [6:0]           out_ctrl,
    output logic [3:0]           out_length,
    output logic                 out_illegal,
    output logic                 halted
);

    localparam int PTR_W = $clog2(QDEPTH);
    typedef logic [PTR_W:0] ptr_t;
    localparam ptr_t c_depth = ptr_t'(QDEPTH);
    localparam ptr_t c_fetch = ptr_t'(FETCH_W);

    logic [7:0]  mem_q [QDEPTH];
    ptr_t        wr_q, rd_q, wr_d, rd_d;
    logic [31:0] pc_q;
    logic        halted_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q, out_imm_q;
    logic [2:0]  out_src1_q, out_src2_q;
    logic [6:0]  out_ctrl_q;
    logic [3:0]  out_len_q;

    ptr_t        w_count, w_free;
    logic        w_push, w_fire;
    logic [39:0] w_head;
    logic [3:0]  w_len;
    logic [31:0] w_imm;
    logic [2:0]  w_src1, w_src2;
    logic [6:0]  w_ctrl;
    logic        w_illegal;

    assign w_count  = wr_q - rd_q;
    assign w_free   = c_depth - w_count;
    assign in_ready = !flush && !halted_q && (w_free >= c_fetch);
    assign w_push   = in_valid && in_ready;

    // Five head bytes, read modulo QDEPTH so an instruction may straddle the wrap point.
    for (genvar k = 0; k < 5; k++) begin : g_head
        logic [PTR_W-1:0] w_idx;
        assign w_idx            = rd_q[PTR_W-1:0] + PTR_W'(k);
        assign w_head[8*k +: 8] = mem_q[w_idx];
    end

    always_comb begin
        w_len     = 4'd1;
        w_imm     = 32'd0;
        w_src1    = 3'd0;
        w_src2    = 3'd0;
        w_ctrl    = 7'b0000000;
        w_illegal = 1'b0;
        casez (w_head[7:0])
            8'b1011_1???: begin
                w_len  = 4'd5;
                w_imm  = w_head[39:8];
                w_src1 = w_head[2:0];
                w_ctrl = 7'b1000100;
            end
            8'h05: begin
                w_len  = 4'd5;
                w_imm  = w_head[39:8];
                w_ctrl = 7'b1110100;
            end
            8'h01: begin
                w_len  = 4'd2;
                w_src1 = w_head[10:8];
                w_src2 = w_head[13:11];
                w_ctrl = 7'b0111100;
            end
            8'h83: begin
                w_len  = 4'd3;
                w_src1 = w_head[10:8];
                w_imm  = {{24{w_head[23]}}, w_head[23:16]};
                w_ctrl = 7'b1110100;
            end
            8'hE9: begin
                w_len  = 4'd5;
                w_imm  = w_head[39:8];
                w_ctrl = 7'b0000010;
            end
            8'hF4: begin
                w_ctrl = 7'b0000001;
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                w_ctrl    = 7'b0000001;
                w_illegal = 1'b1;
`endif
            end
        endcase
    end

    assign w_fire = (32'(w_count) >= 32'(w_len)) && (!out_valid_q || out_ready)
                    && !halted_q && !flush;

    assign wr_d = w_push ? wr_q + c_fetch : wr_q;
    assign rd_d = w_fire ? rd_q + ptr_t'(w_len) : rd_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < FETCH_W; i++) begin
                mem_q[wr_q[PTR_W-1:0] + PTR_W'(i)] <= in_bytes[8*i +: 8];
            end
        end
    end

    // Flush outranks push, fire and halt; the halt bit of the fired ctrl word makes halt sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            pc_q        <= RESET_PC;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            out_imm_q   <= 32'd0;
            out_src1_q  <= 3'd0;
            out_src2_q  <= 3'd0;
            out_ctrl_q  <= 7'd0;
            out_len_q   <= 4'd0;
        end else if (flush) begin
            wr_q        <= '0;
            rd_q        <= '0;
            pc_q        <= flush_pc;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (w_fire) begin
                pc_q        <= pc_q + 32'(w_len);
                out_valid_q <= 1'b1;
                out_pc_q    <= pc_q;
                out_imm_q   <= w_imm;
                out_src1_q  <= w_src1;
                out_src2_q  <= w_src2;
                out_ctrl_q  <= w_ctrl;
                out_len_q   <= w_len;
                if (w_ctrl[0]) begin
                    halted_q <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic out_illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_illegal_q <= 1'b0;
        end else if (!flush && w_fire) begin
            out_illegal_q <= w_illegal;
        end
    end
    assign out_illegal = out_illegal_q;
`else
    logic w_illegal_unused;
    assign w_illegal_unused = w_illegal;
    assign out_illegal      = 1'b0;
`endif

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_imm      = out_imm_q;
    assign out_src1_idx = out_src1_q;
    assign out_src2_idx = out_src2_q;
    assign out_ctrl     = out_ctrl_q;
    assign out_length   = out_len_q;
    assign halted       = halted_q;

endmodule

`default_nettype wire
